// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit and its lane-alignment helper.
//   - Access-size encodings as they arrive on req_size.
//   - FSM state type for the load/store unit.
//   - Default base byte address of data-memory word 0.
//   - Conversion from a byte address to a data-memory word index.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    ERROR  = 2'd3
  } lsu_state_t;

  // Word index of a byte address relative to the memory base.
  // Only meaningful for addresses that already passed the range check.
  function automatic logic [31:0] byte_to_word_index(input logic [31:0] addr,
                                                      input logic [31:0] base);
    logic [31:0] offset;
    offset = addr - base;
    return {2'b00, offset[31:2]};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for sub-word memory accesses.
// Ports:
//   byte_off    in  2   addr[1:0] of the access (little-endian lane select)
//   size        in  2   SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   is_unsigned in  1   zero-extend loads when set, sign-extend otherwise
//   read_word   in  32  word read from data memory
//   store_data  in  32  store data; low byte/half used for sub-word stores
//   load_data   out 32  selected lane, extended to 32 bits
//   merged_word out 32  read_word with the target lane replaced by store data
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] read_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;

  // Halfword lane only depends on addr[1]; alignment of addr[0] is
  // enforced before this block is ever used for a halfword.
  assign byte_shift = {byte_off, 3'b000};
  assign half_shift = {byte_off[1], 4'b0000};

  assign byte_lane = read_word[byte_shift +: 8];
  assign half_lane = read_word[half_shift +: 16];

  always_comb begin
    load_data = read_word;
    case (size)
      SIZE_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default:   load_data = read_word;
    endcase
  end

  always_comb begin
    merged_word = read_word;
    case (size)
      SIZE_BYTE: merged_word[byte_shift +: 8]  = store_data[7:0];
      SIZE_HALF: merged_word[half_shift +: 16] = store_data[15:0];
      default:   merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM pipeline stage and a word-wide data memory
// (asynchronous read, posedge write). One request in flight at a time;
// sub-word stores are performed as read-modify-write.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_valid/ready            request handshake (ready only in IDLE)
//   req_store, req_size,
//   req_unsigned, req_addr,
//   req_wdata                  request fields, latched on acceptance
//   done, err, rdata           completion pulse, error flag, load result
//   dm_address, dm_write_data,
//   dm_mem_write, dm_mem_read,
//   dm_read_data               data-memory interface
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dm_address,
  output logic [DATA_WIDTH-1:0] dm_write_data,
  output logic                  dm_mem_write,
  output logic                  dm_mem_read,
  input  logic [DATA_WIDTH-1:0] dm_read_data
);

  // One past the last valid byte address, kept 33 bits wide so a memory
  // ending at the top of the address space does not wrap.
  localparam logic [32:0] LIMIT_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEMORY_DEPTH);

  lsu_state_t  state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        size_ok;
  logic        align_ok;
  logic        range_ok;
  logic        req_ok;
  logic [31:0] word_idx;
  logic [31:0] lane_load_data;
  logic [31:0] lane_merged_word;

  logic [31:0] dm_address_c;
  logic [31:0] dm_write_data_c;
  logic        dm_mem_write_c;
  logic        dm_mem_read_c;

  // Checks are evaluated on the live request so the accept edge already
  // knows whether to head for ACCESS or ERROR.
  always_comb begin
    size_ok  = (req_size != 2'b11);
    align_ok = 1'b1;
    case (req_size)
      SIZE_HALF: align_ok = ~req_addr[0];
      SIZE_WORD: align_ok = (req_addr[1:0] == 2'b00);
      default:   align_ok = 1'b1;
    endcase
    range_ok = ({1'b0, req_addr} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, req_addr} < LIMIT_ADDR);
    req_ok   = size_ok & align_ok & range_ok;
  end

  assign word_idx = byte_to_word_index(addr_q, BASE_ADDR);

  lsu_lane_align u_lane_align (
    .byte_off    (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .read_word   (dm_read_data),
    .store_data  (wdata_q),
    .load_data   (lane_load_data),
    .merged_word (lane_merged_word)
  );

  always_comb begin
    state_d         = state_q;
    store_d         = store_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    merged_d        = merged_q;
    rdata_d         = rdata_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    dm_address_c    = '0;
    dm_write_data_c = '0;
    dm_mem_write_c  = 1'b0;
    dm_mem_read_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d    = req_store;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          state_d    = req_ok ? ACCESS : ERROR;
        end
      end

      ACCESS: begin
        dm_address_c = word_idx;
        if (store_q && size_q == SIZE_WORD) begin
          dm_write_data_c = wdata_q;
          dm_mem_write_c  = 1'b1;
          state_d         = IDLE;
          done_d          = 1'b1;
        end else if (store_q) begin
          // Sub-word store: capture the merged word, write it next cycle.
          dm_mem_read_c = 1'b1;
          merged_d      = lane_merged_word;
          state_d       = WRITE;
        end else begin
          dm_mem_read_c = 1'b1;
          rdata_d       = lane_load_data;
          state_d       = IDLE;
          done_d        = 1'b1;
        end
      end

      WRITE: begin
        dm_address_c    = word_idx;
        dm_write_data_c = merged_q;
        dm_mem_write_c  = 1'b1;
        state_d         = IDLE;
        done_d          = 1'b1;
      end

      ERROR: begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merged_q   <= merged_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ready         = (state_q == IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign dm_address    = dm_address_c;
  assign dm_write_data = dm_write_data_c;
  // The FSM state is not cleared until the reset edge itself, so the write
  // enable is masked directly to keep an aborted store out of memory.
  assign dm_mem_write  = dm_mem_write_c & ~reset;
  assign dm_mem_read   = dm_mem_read_c;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic        dm_mem_write;
  logic        dm_mem_read;
  logic [31:0] dm_read_data;

  int n_vec  = 0;
  int n_miss = 0;
  logic chk_en = 1'b0;
  logic wr_seen = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(
    .DATA_WIDTH   (32),
    .MEMORY_DEPTH (DEPTH),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .ready         (ready),
    .req_store     (req_store),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_mem_write  (dm_mem_write),
    .dm_mem_read   (dm_mem_read),
    .dm_read_data  (dm_read_data)
  );

  // Data memory: asynchronous read, posedge write.
  logic [31:0] mem [DEPTH];
  assign dm_read_data = (dm_address < DEPTH) ? mem[dm_address[9:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (dm_mem_write && dm_address < DEPTH) mem[dm_address[9:0]] <= dm_write_data;
    if (dm_mem_write) wr_seen <= 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] ref_mem [DEPTH];
  int          m_cnt = 0;
  logic        m_done = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        p_store, p_un, p_err;
  logic [1:0]  p_size;
  logic [31:0] p_addr, p_wdata;

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                         input logic [1:0] sz, input logic un);
    longint v;
    case (sz)
      2'd0: begin v = (w >> (8 * off)) & 255;        if (!un && v >= 128)   v -= 256;   end
      2'd1: begin v = (w >> (16 * off[1])) & 65535;  if (!un && v >= 32768) v -= 65536; end
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask, data;
    if (sz == 2'd0) begin
      mask = 32'hFF << (8 * off);
      data = (wd & 32'hFF) << (8 * off);
    end else begin
      mask = 32'hFFFF << (16 * off[1]);
      data = (wd & 32'hFFFF) << (16 * off[1]);
    end
    return (w & ~mask) | data;
  endfunction

  function automatic logic m_bad(input logic [1:0] sz, input logic [31:0] a);
    longint ai;
    ai = a;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a % 2 != 0) return 1'b1;
    if (sz == 2'd2 && a % 4 != 0) return 1'b1;
    if (ai < longint'(BASE) || ai >= longint'(BASE) + 4 * longint'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    int idx;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (reset) begin
      m_cnt   = 0;
      m_rdata = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_err  = p_err;
        idx    = int'((p_addr - BASE) >> 2);
        if (!p_err && !p_store) m_rdata = m_load(ref_mem[idx], p_addr[1:0], p_size, p_un);
        if (!p_err && p_store)
          ref_mem[idx] = (p_size == 2'd2) ? p_wdata : m_merge(ref_mem[idx], p_addr[1:0], p_size, p_wdata);
      end
    end else if (req_valid) begin
      p_store = req_store; p_size = req_size; p_un = req_unsigned;
      p_addr  = req_addr;  p_wdata = req_wdata;
      p_err   = m_bad(req_size, req_addr);
      // cycles from accept edge to done: errors/loads/SW 2, SB/SH 3
      m_cnt   = (!p_err && p_store && p_size != 2'd2) ? 2 : 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'd0, ready}, {31'd0, m_cnt == 0});
      check("done",  {31'd0, done},  {31'd0, m_done});
      check("err",   {31'd0, err},   {31'd0, m_err});
      check("rdata", rdata, m_rdata);
      for (int k = 0; k < 4; k++) check($sformatf("mem%0d", k), mem[k], ref_mem[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    check({nm, "_latency"}, lat, exp_lat);
  endtask

  task automatic present(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
    req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lat);
    @(negedge clk);
    present(st, sz, un, a, wd);
    wait_done(nm, exp_lat);
    $display("op %s addr=%h size=%0d store=%0d -> err=%0d rdata=%h", nm, a, sz, st, err, rdata);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[0] = 32'h8899_AABB;
    ref_mem[0] = 32'h8899_AABB;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_dm_addr", dm_address, 32'd0);
    check("rst_dm_rd", {31'd0, dm_mem_read}, 32'd0);

    run_op("LB",  1'b0, 2'd0, 1'b0, BASE + 1, 32'd0, 2);
    check("LB_rdata", rdata, 32'hFFFF_FFAA);
    run_op("LBU", 1'b0, 2'd0, 1'b1, BASE + 1, 32'd0, 2);
    check("LBU_rdata", rdata, 32'h0000_00AA);
    run_op("LH",  1'b0, 2'd1, 1'b0, BASE + 2, 32'd0, 2);
    check("LH_rdata", rdata, 32'hFFFF_8899);
    run_op("LHU", 1'b0, 2'd1, 1'b1, BASE, 32'd0, 2);
    check("LHU_rdata", rdata, 32'h0000_AABB);
    run_op("LW",  1'b0, 2'd2, 1'b0, BASE, 32'd0, 2);
    check("LW_rdata", rdata, 32'h8899_AABB);

    run_op("SB",  1'b1, 2'd0, 1'b0, BASE + 2, 32'h0000_0011, 3);
    check("SB_word0", mem[0], 32'h8811_AABB);

    wr_seen = 1'b0;
    run_op("SH_misaligned", 1'b1, 2'd1, 1'b0, BASE + 1, 32'h0000_BEEF, 2);
    check("SH_mis_err", {31'd0, err}, 32'd1);
    check("SH_mis_nowrite", {31'd0, wr_seen}, 32'd0);
    check("SH_mis_word0", mem[0], 32'h8811_AABB);

    run_op("LW_top", 1'b0, 2'd2, 1'b0, BASE + 4 * DEPTH, 32'd0, 2);
    check("LW_top_err", {31'd0, err}, 32'd1);
    run_op("LW_below", 1'b0, 2'd2, 1'b0, BASE - 4, 32'd0, 2);
    check("LW_below_err", {31'd0, err}, 32'd1);
    run_op("L_size3", 1'b0, 2'd3, 1'b0, BASE, 32'd0, 2);
    check("size3_err", {31'd0, err}, 32'd1);
    check("size3_rdata_held", rdata, 32'h8899_AABB);

    // SH aborted by reset while in WRITE.
    @(negedge clk);
    present(1'b1, 2'd1, 1'b0, BASE + 2, 32'h0000_CAFE);
    @(negedge clk);             // ACCESS
    @(negedge clk);             // WRITE
    reset = 1'b1;
    #1 check("rst_gate_write", {31'd0, dm_mem_write}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_done",  {31'd0, done},  32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_word0", mem[0], 32'h8811_AABB);
    $display("op SH_abort addr=%h -> word0=%h", BASE + 2, mem[0]);

    run_op("SB_hi", 1'b1, 2'd0, 1'b0, BASE + 7, 32'hFFFF_FF5A, 3);
    check("SB_hi_word1", mem[1], 32'h5A00_0000);
    run_op("LB_hi", 1'b0, 2'd0, 1'b0, BASE + 7, 32'd0, 2);
    check("LB_hi_rdata", rdata, 32'h0000_005A);

    // Back-to-back: LW presented in the SW done cycle.
    @(negedge clk);
    present(1'b1, 2'd2, 1'b0, BASE + 8, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    check("b2b_sw_done", {31'd0, done}, 32'd1);
    present(1'b0, 2'd2, 1'b0, BASE + 8, 32'd0);
    wait_done("b2b_lw", 2);
    check("b2b_lw_rdata", rdata, 32'h1234_5678);
    $display("op b2b SW/LW addr=%h -> rdata=%h", BASE + 8, rdata);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
